// File: rtl/carfield_pkg.sv
// carfield_pkg: shared constants and domain state encoding for the power-domain sequencer
package carfield_pkg;
  localparam int unsigned NumDomains = 6;
  localparam int unsigned PeriphDomainIdx = 0;
  localparam int unsigned DomClkSettleCycles = 4;
  localparam int unsigned DomRstHoldCycles = 16;
  localparam int unsigned DomIsoTimeout = 256;
  localparam logic [NumDomains-1:0] AlwaysOnMask = NumDomains'(1) << PeriphDomainIdx;
  typedef enum logic [2:0] {
    DomOff,
    DomClkSettle,
    DomRstRel,
    DomDeiso,
    DomActive,
    DomIso,
    DomRstAssert
  } domain_state_e;
  function automatic int unsigned dom_max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction
endpackage

// File: rtl/carfield_domain_fsm.sv
// carfield_domain_fsm: per-domain clock/reset/isolation sequencing FSM with its own counter and timeout flag
module carfield_domain_fsm import carfield_pkg::*; #(
  parameter int unsigned ClkSettleCycles = DomClkSettleCycles,
  parameter int unsigned RstHoldCycles = DomRstHoldCycles,
  parameter int unsigned IsoTimeout = DomIsoTimeout
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic grant,
  input  logic req,
  input  logic swrst,
  input  logic ack,
  input  logic err_clr,
  output logic clk_en,
  output logic rst_n,
  output logic iso,
  output logic active,
  output logic err,
  output logic pending,
  output logic transient
);
  localparam int unsigned CntW = $clog2(dom_max3(ClkSettleCycles, RstHoldCycles, IsoTimeout) + 1);
  typedef logic [CntW-1:0] cnt_t;
  domain_state_e state_q, state_d;
  cnt_t cnt_q, cnt_d;
  logic swrst_q, swrst_d, timeout, done;
  function automatic cnt_t reload(domain_state_e s);
    return (s == DomClkSettle || s == DomRstAssert) ? cnt_t'(ClkSettleCycles) :
           (s == DomRstRel) ? cnt_t'(RstHoldCycles) :
           (s == DomDeiso || s == DomIso) ? cnt_t'(IsoTimeout) : '0;
  endfunction
  assign done = cnt_q == cnt_t'(1);
  assign cnt_d = (state_d != state_q) ? reload(state_d) : (cnt_q > cnt_t'(1)) ? cnt_q - cnt_t'(1) : cnt_q;
  assign swrst_d = (state_q == DomRstAssert && done) ? 1'b0 : swrst_q | (state_q == DomActive && swrst);
  assign pending = (state_d == DomOff && req) || (state_d == DomActive && (!req || swrst_d));
  assign transient = !(state_d inside {DomOff, DomActive});
  // Next state; a missing isolation ack past the timeout advances as if acked and flags the error
  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    case (state_q)
      DomOff:       state_d = grant ? DomClkSettle : DomOff;
      DomClkSettle: state_d = done ? DomRstRel : DomClkSettle;
      DomRstRel:    state_d = done ? DomDeiso : DomRstRel;
      DomDeiso: begin
        timeout = ack & done;
        state_d = (!ack || done) ? DomActive : DomDeiso;
      end
      DomActive:    state_d = grant ? DomIso : DomActive;
      DomIso: begin
        timeout = !ack & done;
        state_d = (ack || done) ? DomRstAssert : DomIso;
      end
      DomRstAssert: state_d = !done ? DomRstAssert : (swrst_q && req) ? DomClkSettle : DomOff;
      default:      state_d = DomOff;
    endcase
  end
  // State, counter and Moore outputs decoded from the next state so every output is a flop
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= DomOff;
      cnt_q   <= '0;
      swrst_q <= 1'b0;
      err     <= 1'b0;
      clk_en  <= 1'b0;
      rst_n   <= 1'b0;
      iso     <= 1'b1;
      active  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      swrst_q <= swrst_d;
      err     <= timeout | (err & ~err_clr);
      clk_en  <= state_d != DomOff;
      rst_n   <= state_d inside {DomRstRel, DomDeiso, DomActive, DomIso};
      iso     <= !(state_d inside {DomDeiso, DomActive});
      active  <= state_d == DomActive;
    end
  end
endmodule

// File: rtl/carfield_domain_seq.sv
// carfield_domain_seq: serialises power transitions of the Carfield subdomains, one domain at a time
module carfield_domain_seq #(
  parameter int unsigned NumDomains = carfield_pkg::NumDomains,
  parameter int unsigned ClkSettleCycles = carfield_pkg::DomClkSettleCycles,
  parameter int unsigned RstHoldCycles = carfield_pkg::DomRstHoldCycles,
  parameter int unsigned IsoTimeout = carfield_pkg::DomIsoTimeout,
  parameter logic [NumDomains-1:0] AlwaysOnMask = carfield_pkg::AlwaysOnMask
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NumDomains-1:0] domain_en_i,
  input  logic [NumDomains-1:0] domain_swrst_i,
  input  logic [NumDomains-1:0] iso_ack_i,
  input  logic                  err_clr_i,
  output logic [NumDomains-1:0] domain_clk_en_o,
  output logic [NumDomains-1:0] domain_rst_no,
  output logic [NumDomains-1:0] domain_iso_o,
  output logic [NumDomains-1:0] domain_active_o,
  output logic [NumDomains-1:0] err_o,
  output logic                  busy_o
);
  logic [NumDomains-1:0] req, pending, transient, gnt_q, gnt_d;
  assign req = domain_en_i | AlwaysOnMask;
  assign gnt_d = (|transient) ? '0 : pending & (~pending + NumDomains'(1));
  // Registered one-hot grant; a granted domain already counts as busy so busy never dips between sequences
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gnt_q  <= '0;
      busy_o <= 1'b0;
    end else begin
      gnt_q  <= gnt_d;
      busy_o <= (|transient) | (|gnt_d);
    end
  end
  for (genvar i = 0; i < NumDomains; i++) begin : g_dom
    carfield_domain_fsm #(
      .ClkSettleCycles(ClkSettleCycles),
      .RstHoldCycles(RstHoldCycles),
      .IsoTimeout(IsoTimeout)
    ) u_fsm (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .grant(gnt_q[i]),
      .req(req[i]),
      .swrst(domain_swrst_i[i]),
      .ack(iso_ack_i[i]),
      .err_clr(err_clr_i),
      .clk_en(domain_clk_en_o[i]),
      .rst_n(domain_rst_no[i]),
      .iso(domain_iso_o[i]),
      .active(domain_active_o[i]),
      .err(err_o[i]),
      .pending(pending[i]),
      .transient(transient[i])
    );
  end
endmodule
